// File: rtl/pwm_deadtime_driver_if.sv
// Signal bundle between the PWM generator / fault button side and the gate driver.
// The driver core connects through the slave modport; stimulus or upstream logic uses master.
interface pwm_deadtime_driver_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   pwm_in;
    logic                   fault_in;
    logic                   fault_clr;
    logic                   gate_hi;
    logic                   gate_lo;
    logic                   fault_latched;
    logic [COUNT_WIDTH-1:0] pulse_count;
    logic [2:0]             state_out;

    modport master (
        output pwm_in, fault_in, fault_clr,
        input  gate_hi, gate_lo, fault_latched, pulse_count, state_out
    );

    modport slave (
        input  pwm_in, fault_in, fault_clr,
        output gate_hi, gate_lo, fault_latched, pulse_count, state_out
    );
endinterface

// File: rtl/pwm_deadtime_driver.sv
// Complementary gate driver with dead-time insertion, a debounced latching fault path,
// and a count of high-side pulses for the debug LEDs.
module pwm_deadtime_driver #(
    parameter int DEADTIME_CYCLES = 12,
    parameter int FAULT_DEBOUNCE  = 120000,
    parameter int COUNT_WIDTH     = 16
) (
    input logic                  clk,
    input logic                  rst,
    pwm_deadtime_driver_if.slave bus
);
    localparam int              DB_W    = $clog2(FAULT_DEBOUNCE + 1);
    localparam logic [15:0]     DT_LAST = 16'(DEADTIME_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(FAULT_DEBOUNCE - 1);

    typedef enum logic [2:0] {
        LO_ON   = 3'd0,
        DT_RISE = 3'd1,
        HI_ON   = 3'd2,
        DT_FALL = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   pwm_q;
    logic [1:0]             sync;
    logic                   fault_db;
    logic [DB_W-1:0]        db_cnt;
    logic [15:0]            dt_cnt;
    logic [15:0]            dt_cnt_next;
    logic                   gate_hi_q;
    logic                   gate_lo_q;
    logic                   fault_q;
    logic [COUNT_WIDTH-1:0] pulse_q;

    // Fault has absolute priority; otherwise each state follows pwm_q, with the
    // dead-time states returning immediately to the side that was just on.
    always_comb begin
        next_state  = state;
        dt_cnt_next = dt_cnt;
        if (state != FAULT && fault_db) begin
            next_state = FAULT;
        end else begin
            case (state)
                LO_ON: begin
                    if (pwm_q) begin
                        next_state  = DT_RISE;
                        dt_cnt_next = '0;
                    end
                end
                DT_RISE: begin
                    if (!pwm_q) begin
                        next_state = LO_ON;
                    end else if (dt_cnt == DT_LAST) begin
                        next_state = HI_ON;
                    end else begin
                        dt_cnt_next = dt_cnt + 16'd1;
                    end
                end
                HI_ON: begin
                    if (!pwm_q) begin
                        next_state  = DT_FALL;
                        dt_cnt_next = '0;
                    end
                end
                DT_FALL: begin
                    if (pwm_q) begin
                        next_state = HI_ON;
                    end else if (dt_cnt == DT_LAST) begin
                        next_state = LO_ON;
                    end else begin
                        dt_cnt_next = dt_cnt + 16'd1;
                    end
                end
                FAULT: begin
                    if (bus.fault_clr && !fault_db) begin
                        next_state  = DT_FALL;
                        dt_cnt_next = '0;
                    end
                end
                default: begin
                    next_state  = DT_FALL;
                    dt_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q     <= 1'b0;
            sync      <= '0;
            fault_db  <= 1'b0;
            db_cnt    <= '0;
            state     <= DT_FALL;
            dt_cnt    <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            fault_q   <= 1'b0;
            pulse_q   <= '0;
        end else begin
            pwm_q <= bus.pwm_in;
            sync  <= {sync[0], bus.fault_in};

            if (sync[1] != fault_db) begin
                if (db_cnt == DB_LAST) begin
                    fault_db <= ~fault_db;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            state     <= next_state;
            dt_cnt    <= dt_cnt_next;
            // Pins are registered decodes of next_state so they align with state.
            gate_hi_q <= (next_state == HI_ON);
            gate_lo_q <= (next_state == LO_ON);
            fault_q   <= (next_state == FAULT);
            if (next_state == HI_ON && state != HI_ON) begin
                pulse_q <= pulse_q + 1'b1;
            end
        end
    end

    assign bus.gate_hi       = gate_hi_q;
    assign bus.gate_lo       = gate_lo_q;
    assign bus.fault_latched = fault_q;
    assign bus.pulse_count   = pulse_q;
    assign bus.state_out     = state;
endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Bench for pwm_deadtime_driver: directed scenarios with literal expectations plus a
// long randomized run compared every cycle against a side/off-window behavioural model.
module tb_pwm_deadtime_driver;
    localparam int DT = 3;
    localparam int FD = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_deadtime_driver_if #(.COUNT_WIDTH(CW)) bus ();

    pwm_deadtime_driver #(
        .DEADTIME_CYCLES(DT),
        .FAULT_DEBOUNCE (FD),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: which side conducts, which side conducted last, how long both
    // have been off, and whether a fault is latched.
    logic          m_valid = 1'b0;
    logic          m_hi, m_lo, m_last_hi, m_faulted;
    int            m_off_len;
    logic          m_pwm_q;
    logic [1:0]    m_sync;
    logic          m_db;
    int            m_run;
    logic [CW-1:0] m_pulses;

    always @(posedge clk) begin
        logic want_hi;
        if (rst) begin
            m_valid   = 1'b1;
            m_hi      = 1'b0;
            m_lo      = 1'b0;
            m_last_hi = 1'b1;
            m_off_len = 1;
            m_faulted = 1'b0;
            m_pwm_q   = 1'b0;
            m_sync    = '0;
            m_db      = 1'b0;
            m_run     = 0;
            m_pulses  = '0;
        end else if (m_valid) begin
            want_hi = m_pwm_q;
            if (m_faulted) begin
                if (bus.fault_clr && !m_db) begin
                    m_faulted = 1'b0;
                    m_last_hi = 1'b1;
                    m_off_len = 1;
                end
            end else if (m_db) begin
                m_faulted = 1'b1;
                m_hi = 1'b0;
                m_lo = 1'b0;
            end else if (m_hi || m_lo) begin
                if (m_hi != want_hi) begin
                    m_last_hi = m_hi;
                    m_hi = 1'b0;
                    m_lo = 1'b0;
                    m_off_len = 1;
                end
            end else if (want_hi == m_last_hi || m_off_len >= DT) begin
                m_hi = want_hi;
                m_lo = !want_hi;
                if (want_hi) m_pulses = m_pulses + 1'b1;
            end else begin
                m_off_len++;
            end

            if (m_sync[1] != m_db) begin
                m_run++;
                if (m_run == FD) begin
                    m_db  = !m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_sync  = {m_sync[0], bus.fault_in};
            m_pwm_q = bus.pwm_in;
        end
    end

    // Per-cycle comparison plus independent overlap / dead-time watch on the pins.
    int mon_last = 0;
    int mon_off  = 0;

    always @(negedge clk) begin
        int side;
        int exp_state;
        if (m_valid) begin
            exp_state = m_faulted ? 4 : m_hi ? 2 : m_lo ? 0 : m_last_hi ? 3 : 1;
            chk("gate_hi", int'(bus.gate_hi), int'(m_hi));
            chk("gate_lo", int'(bus.gate_lo), int'(m_lo));
            chk("fault_latched", int'(bus.fault_latched), int'(m_faulted));
            chk("pulse_count", int'(bus.pulse_count), int'(m_pulses));
            chk("state_out", int'(bus.state_out), exp_state);
            chk("overlap", int'(bus.gate_hi & bus.gate_lo), 0);

            if (bus.gate_hi || bus.gate_lo) begin
                side = bus.gate_hi ? 2 : 1;
                if (mon_last != 0 && side != mon_last)
                    chk("deadtime_window", int'(mon_off >= DT), 1);
                mon_last = side;
                mon_off  = 0;
            end else begin
                mon_off++;
            end
        end
    end

    initial begin
        int first_hi, last_hi, lo_back, hi_cnt;
        int hold, fburst, rhold;

        bus.pwm_in    = 1'b0;
        bus.fault_in  = 1'b0;
        bus.fault_clr = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gate_hi", int'(bus.gate_hi), 0);
        chk("rst_gate_lo", int'(bus.gate_lo), 0);
        chk("rst_fault", int'(bus.fault_latched), 0);
        chk("rst_pulses", int'(bus.pulse_count), 0);
        chk("rst_state", int'(bus.state_out), 3);

        // Release: both off for DT cycles, then the low side.
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("startup_lo", int'(bus.gate_lo), (i == 3) ? 1 : 0);
        end
        chk("startup_state", int'(bus.state_out), 0);

        // 10-cycle pulse: lo off at 1, hi at 4..10, lo back at 14.
        first_hi = -1; last_hi = -1; lo_back = -1; hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            bus.pwm_in = (i < 10);
            @(negedge clk);
            if (i == 1) chk("lo_falls", int'(bus.gate_lo), 0);
            if (bus.gate_hi) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            if (bus.gate_lo && last_hi >= 0 && lo_back < 0) lo_back = i;
        end
        chk("pulse_hi_first", first_hi, 4);
        chk("pulse_hi_len", hi_cnt, 7);
        chk("pulse_lo_back", lo_back, 14);
        chk("pulse_count_1", int'(bus.pulse_count), 1);

        // 2-cycle pulse is absorbed in the rising dead-time window.
        hi_cnt = 0; lo_back = -1;
        for (int i = 0; i < 15; i++) begin
            bus.pwm_in = (i < 2);
            @(negedge clk);
            if (bus.gate_hi) hi_cnt++;
            if (i >= 1 && bus.gate_lo && lo_back < 0) lo_back = i;
        end
        chk("short_hi_len", hi_cnt, 0);
        chk("short_lo_back", lo_back, 3);
        chk("short_pulses", int'(bus.pulse_count), 1);

        // Enter HI_ON, then a 3-cycle fault glitch that must not latch.
        bus.pwm_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("hi_before_glitch", int'(bus.gate_hi), 1);
        hi_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            bus.fault_in = (i < 3);
            @(negedge clk);
            if (bus.gate_hi) hi_cnt++;
        end
        chk("glitch_hi_held", hi_cnt, 12);
        chk("glitch_no_fault", int'(bus.fault_latched), 0);

        // Steady fault: gates drop six edges after the first sample.
        for (int i = 0; i < 10; i++) begin
            bus.fault_in = 1'b1;
            @(negedge clk);
            if (i == 5) chk("fault_hi_still", int'(bus.gate_hi), 1);
            if (i == 6) begin
                chk("fault_hi_off", int'(bus.gate_hi), 0);
                chk("fault_lo_off", int'(bus.gate_lo), 0);
                chk("fault_latched", int'(bus.fault_latched), 1);
                chk("fault_state", int'(bus.state_out), 4);
            end
        end
        chk("fault_pulses_held", int'(bus.pulse_count), 2);

        // Clear ignored while the debounced fault is still high.
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_ignored", int'(bus.state_out), 4);

        bus.fault_in = 1'b0;
        bus.pwm_in   = 1'b0;
        repeat (10) @(negedge clk);
        chk("still_latched", int'(bus.fault_latched), 1);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_state", int'(bus.state_out), 3);
        chk("clr_unlatched", int'(bus.fault_latched), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("clr_lo", int'(bus.gate_lo), (i == 3) ? 1 : 0);
        end

        // Randomized run: pwm runs around the dead time, fault bursts, clears, resets.
        hold = 0; fburst = 0; rhold = 0;
        for (int i = 0; i < 30000; i++) begin
            if (hold == 0) begin
                bus.pwm_in = 1'($urandom_range(1, 0));
                hold = $urandom_range(10, 1);
            end
            hold--;
            if (fburst > 0) begin
                bus.fault_in = 1'b1;
                fburst--;
            end else begin
                bus.fault_in = 1'b0;
                if ($urandom_range(799, 0) == 0) fburst = $urandom_range(14, 1);
            end
            bus.fault_clr = ($urandom_range(15, 0) == 0);
            if (rhold > 0) begin
                rst = 1'b1;
                rhold--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(2999, 0) == 0) rhold = $urandom_range(3, 1);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
